mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 4, giving SRAM access cycles per transaction (legal 1..15).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports, in order: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request, level, held until if_ready.
REQ-006 if_addr  input  32  fetch address.
REQ-007 if_rdata  output  32  fetched word.
REQ-008 if_ready  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-009 mem_r_en  input  1  data-load request, level.
REQ-010 mem_w_en  input  1  data-store request, level.
REQ-011 mem_addr  input  32  data address.
REQ-012 mem_wdata  input  32  store data.
REQ-013 mem_rdata  output  32  loaded word.
REQ-014 mem_ready  output  1  one-cycle pulse: data access complete.
REQ-015 sram_addr  output  32  shared SRAM address.
REQ-016 sram_wdata  output  32  shared SRAM write data.
REQ-017 sram_rdata  input  32  shared SRAM read data.
REQ-018 sram_re, sram_we  output  1 each  SRAM read/write strobes, active-high.
REQ-019 freeze  output  1  pipeline stall request.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 States SHALL be IDLE, ACCESS, DONE; 4-bit down-counter cnt; 1-bit last_grant (0=IF, 1=MEM).
REQ-022 IDLE: no request -> stay; one requester pending -> grant it; both pending -> grant the one not equal to last_grant.
REQ-023 Data request pending SHALL mean mem_r_en|mem_w_en; mem_r_en and mem_w_en both high SHALL be treated as a write.
REQ-024 On grant edge: latch addr, wdata and op (read/write), set cnt=WAIT_CYCLES-1, update last_grant, go to ACCESS.
REQ-025 ACCESS: sram_addr/sram_wdata driven from latched registers; sram_re=1 for reads or sram_we=1 for writes, every ACCESS cycle; cnt decrements each cycle.
REQ-026 ACCESS with cnt==0: on that edge capture sram_rdata into the granted requester's rdata register (reads only) and go to DONE.
REQ-027 DONE: assert the granted requester's ready for exactly one cycle; sram_re=sram_we=0; next state IDLE unconditionally.
REQ-028 Latency: request sampled in IDLE at cycle 0 -> ready high in cycle WAIT_CYCLES+1; back-to-back transactions spaced WAIT_CYCLES+2 cycles.
REQ-029 if_rdata/mem_rdata SHALL hold their value until the next read completion for that requester.
REQ-030 sram_re and sram_we SHALL never be high together; both SHALL be 0 outside ACCESS.
REQ-031 Input changes during ACCESS SHALL NOT affect the transaction in flight.
REQ-032 A request dropped mid-transaction SHALL still complete; its ready pulse is still issued.
REQ-033 freeze SHALL be combinational: (if_req & ~if_ready) | ((mem_r_en|mem_w_en) & ~mem_ready).
REQ-034 In the DONE cycle, the ready requester SHALL NOT be considered pending for arbitration in the following IDLE cycle unless its request is still high there.

Reset
REQ-035 With rst high at an edge: state=IDLE, cnt=0, last_grant=0, latched addr/wdata=0, if_rdata=mem_rdata=0.
REQ-036 Outputs during and after reset until a grant: if_ready=mem_ready=0, sram_re=sram_we=0, sram_addr=sram_wdata=0, busy=0.
REQ-037 Reset mid-ACCESS SHALL abort the transaction with no ready pulse and no rdata update; strobes drop after that edge.

Verification
REQ-038 Single fetch, WAIT_CYCLES=4: if_req=1, if_addr=0x40, sram_rdata=0xE3A01005 -> sram_re high cycles 1..4, if_ready high cycle 5, if_rdata=0xE3A01005, freeze high cycles 0..4.
REQ-039 Store: mem_w_en=1, mem_addr=0x100, mem_wdata=0xDEADBEEF -> sram_we high 4 cycles with sram_addr=0x100, sram_wdata=0xDEADBEEF, mem_ready cycle 5, sram_re never high.
REQ-040 Contention from reset: if_req and mem_r_en both held -> MEM granted first, IF next; ready pulses at cycles 5 and 11.
REQ-041 Both write and read asserted: mem_r_en=mem_w_en=1 -> sram_we only, mem_rdata unchanged.
REQ-042 Reset at cycle 2 of an IF read -> no if_ready, if_rdata=0, sram_re=0 from cycle 3, busy=0.
REQ-043 WAIT_CYCLES=1: single read -> sram_re one cycle (cycle 1), ready cycle 2.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline's two memory ports, the arbiter and the
// shared single-port SRAM. The arbiter uses the slave view; whatever models
// the pipeline and the SRAM uses the master view.
interface mem_arbiter_if;
  // instruction-fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  // data load/store port
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  // shared SRAM side
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_re;
  logic        sram_we;

  // pipeline status
  logic        freeze;
  logic        busy;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ready,
    input  mem_r_en, mem_w_en, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    output sram_addr, sram_wdata,
    input  sram_rdata,
    output sram_re, sram_we,
    output freeze, busy
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ready,
    output mem_r_en, mem_w_en, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    input  sram_addr, sram_wdata,
    output sram_rdata,
    input  sram_re, sram_we,
    input  freeze, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of one shared SRAM. Instruction fetch and data
// load/store compete for the SRAM; ties alternate so neither side starves.
// Each transaction holds the SRAM for WAIT_CYCLES cycles, then spends one
// DONE cycle pulsing the winner's ready, so transactions are spaced
// WAIT_CYCLES+2 cycles apart.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 4
) (
  input logic      clk,
  input logic      rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        last_grant;   // 0 = fetch won last, 1 = data won last
  logic        owner_mem;    // requester that owns the transaction in flight
  logic        op_write;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        if_ready_q;
  logic        mem_ready_q;
  logic        sram_re_q;
  logic        sram_we_q;

  logic        if_pending;
  logic        mem_pending;
  logic        grant_valid;
  logic        grant_mem;

  assign if_pending  = bus.if_req;
  assign mem_pending = bus.mem_r_en | bus.mem_w_en;

  // Pick the winner for this IDLE cycle; on a tie the side that lost last time wins
  always_comb begin
    grant_valid = 1'b0;
    grant_mem   = 1'b0;
    if (if_pending && mem_pending) begin
      grant_valid = 1'b1;
      grant_mem   = ~last_grant;
    end else if (mem_pending) begin
      grant_valid = 1'b1;
      grant_mem   = 1'b1;
    end else if (if_pending) begin
      grant_valid = 1'b1;
      grant_mem   = 1'b0;
    end
  end

  // Transaction FSM: latch the winner's request, hold the SRAM strobes, then pulse ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_grant  <= 1'b0;
      owner_mem   <= 1'b0;
      op_write    <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      sram_re_q   <= 1'b0;
      sram_we_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          if (grant_valid) begin
            owner_mem  <= grant_mem;
            last_grant <= grant_mem;
            cnt        <= CNT_INIT;
            state      <= ACCESS;
            if (grant_mem) begin
              // a simultaneous load and store is resolved as a store
              op_write  <= bus.mem_w_en;
              addr_q    <= bus.mem_addr;
              wdata_q   <= bus.mem_wdata;
              sram_re_q <= ~bus.mem_w_en;
              sram_we_q <= bus.mem_w_en;
            end else begin
              op_write  <= 1'b0;
              addr_q    <= bus.if_addr;
              wdata_q   <= 32'h0;
              sram_re_q <= 1'b1;
              sram_we_q <= 1'b0;
            end
          end
        end

        ACCESS: begin
          if (cnt == 4'd0) begin
            sram_re_q <= 1'b0;
            sram_we_q <= 1'b0;
            state     <= DONE;
            if (owner_mem) begin
              mem_ready_q <= 1'b1;
              if (!op_write) begin
                mem_rdata_q <= bus.sram_rdata;
              end
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= bus.sram_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          sram_re_q   <= 1'b0;
          sram_we_q   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_ready   = if_ready_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.mem_ready  = mem_ready_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_re    = sram_re_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.busy       = (state != IDLE);

  // The pipeline stalls while any of its ports is asking and has not been answered yet
  assign bus.freeze = (bus.if_req & ~if_ready_q) | (mem_pending & ~mem_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT_CYCLES=4 and 1) share one stimulus.
// A transaction-level model predicts every output each cycle; directed
// scenarios with hand-computed values pin the model, then random traffic runs.
module tb_mem_arbiter;

  localparam int NI = 2;
  localparam int W0 = 4;
  localparam int W1 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] sram_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus4 ();
  mem_arbiter_if bus1 ();

  assign bus4.if_req     = if_req;
  assign bus4.if_addr    = if_addr;
  assign bus4.mem_r_en   = mem_r_en;
  assign bus4.mem_w_en   = mem_w_en;
  assign bus4.mem_addr   = mem_addr;
  assign bus4.mem_wdata  = mem_wdata;
  assign bus4.sram_rdata = sram_rdata;
  assign bus1.if_req     = if_req;
  assign bus1.if_addr    = if_addr;
  assign bus1.mem_r_en   = mem_r_en;
  assign bus1.mem_w_en   = mem_w_en;
  assign bus1.mem_addr   = mem_addr;
  assign bus1.mem_wdata  = mem_wdata;
  assign bus1.sram_rdata = sram_rdata;

  mem_arbiter #(.WAIT_CYCLES(W0)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mem_arbiter #(.WAIT_CYCLES(W1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // ---------------- comparison helper ----------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          wc [NI];
  bit          m_act [NI];
  int          m_start [NI];
  bit          m_mem [NI];
  bit          m_wr [NI];
  bit          m_last [NI];
  bit          m_granted [NI];
  logic [31:0] m_addr [NI];
  logic [31:0] m_wdata [NI];
  logic [31:0] m_if_rd [NI];
  logic [31:0] m_mem_rd [NI];
  int          mcyc = 0;
  bit          model_live = 0;
  bit          ip, mp, pick;

  initial begin
    wc[0] = W0;
    wc[1] = W1;
  end

  // A transaction granted at the end of cycle s occupies the SRAM in cycles
  // s+1..s+W, reads the SRAM at the end of cycle s+W, answers in cycle s+W+1.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_act[k]     = 0;
        m_last[k]    = 0;
        m_granted[k] = 0;
        m_addr[k]    = 32'h0;
        m_wdata[k]   = 32'h0;
        m_if_rd[k]   = 32'h0;
        m_mem_rd[k]  = 32'h0;
      end else if (m_act[k]) begin
        if (mcyc == m_start[k] + wc[k] && !m_wr[k]) begin
          if (m_mem[k]) m_mem_rd[k] = sram_rdata;
          else          m_if_rd[k]  = sram_rdata;
        end
        if (mcyc == m_start[k] + wc[k] + 1) m_act[k] = 0;
      end else begin
        ip = if_req;
        mp = mem_r_en | mem_w_en;
        if (ip || mp) begin
          pick         = (ip && mp) ? !m_last[k] : mp;
          m_act[k]     = 1;
          m_start[k]   = mcyc;
          m_mem[k]     = pick;
          m_last[k]    = pick;
          m_granted[k] = 1;
          m_wr[k]      = pick && mem_w_en;
          m_addr[k]    = pick ? mem_addr : if_addr;
          if (pick) m_wdata[k] = mem_wdata;
        end
      end
    end
    mcyc++;
    model_live = 1;
  end

  task automatic compareModel(input int k,
                              input logic [31:0] a_if_rd, input logic a_if_rdy,
                              input logic [31:0] a_mem_rd, input logic a_mem_rdy,
                              input logic [31:0] a_addr, input logic [31:0] a_wdata,
                              input logic a_re, input logic a_we,
                              input logic a_freeze, input logic a_busy);
    int  ph;
    bit  acc, done, e_ifr, e_memr;
    ph     = mcyc - m_start[k];
    acc    = m_act[k] && ph >= 1 && ph <= wc[k];
    done   = m_act[k] && ph == wc[k] + 1;
    e_ifr  = done && !m_mem[k];
    e_memr = done && m_mem[k];
    checkOutput($sformatf("m%0d_if_ready", k),  {31'h0, a_if_rdy},  {31'h0, e_ifr});
    checkOutput($sformatf("m%0d_mem_ready", k), {31'h0, a_mem_rdy}, {31'h0, e_memr});
    checkOutput($sformatf("m%0d_if_rdata", k),  a_if_rd,  m_if_rd[k]);
    checkOutput($sformatf("m%0d_mem_rdata", k), a_mem_rd, m_mem_rd[k]);
    checkOutput($sformatf("m%0d_sram_re", k),   {31'h0, a_re}, {31'h0, acc && !m_wr[k]});
    checkOutput($sformatf("m%0d_sram_we", k),   {31'h0, a_we}, {31'h0, acc && m_wr[k]});
    checkOutput($sformatf("m%0d_busy", k),      {31'h0, a_busy}, {31'h0, m_act[k]});
    checkOutput($sformatf("m%0d_freeze", k),    {31'h0, a_freeze},
                {31'h0, (if_req && !e_ifr) || ((mem_r_en || mem_w_en) && !e_memr)});
    if (acc)
      checkOutput($sformatf("m%0d_sram_addr", k), a_addr, m_addr[k]);
    if (!m_granted[k]) begin
      checkOutput($sformatf("m%0d_addr_rst", k),  a_addr,  32'h0);
      checkOutput($sformatf("m%0d_wdata_rst", k), a_wdata, 32'h0);
    end
    if (acc && m_wr[k])
      checkOutput($sformatf("m%0d_sram_wdata", k), a_wdata, m_wdata[k]);
  endtask

  // Compare both instances against the model in the middle of every cycle
  always @(negedge clk) begin
    if (model_live) begin
      compareModel(0, bus4.if_rdata, bus4.if_ready, bus4.mem_rdata, bus4.mem_ready,
                   bus4.sram_addr, bus4.sram_wdata, bus4.sram_re, bus4.sram_we,
                   bus4.freeze, bus4.busy);
      compareModel(1, bus1.if_rdata, bus1.if_ready, bus1.mem_rdata, bus1.mem_ready,
                   bus1.sram_addr, bus1.sram_wdata, bus1.sram_re, bus1.sram_we,
                   bus1.freeze, bus1.busy);
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic ifr, input logic mr, input logic mw,
                               input logic [31:0] ia, input logic [31:0] ma,
                               input logic [31:0] md);
    if_req    = ifr;
    mem_r_en  = mr;
    mem_w_en  = mw;
    if_addr   = ia;
    mem_addr  = ma;
    mem_wdata = md;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_if_ready", {31'h0, bus4.if_ready}, 32'h0);
    checkOutput("rst_sram_re",  {31'h0, bus4.sram_re},  32'h0);
    checkOutput("rst_busy",     {31'h0, bus4.busy},     32'h0);
    checkOutput("rst_if_rdata", bus4.if_rdata,  32'h0);
    checkOutput("rst_mem_rdata", bus4.mem_rdata, 32'h0);
    checkOutput("rst_sram_addr", bus4.sram_addr, 32'h0);
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst        = 1'b1;
    sram_rdata = 32'h0;
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);

    // single fetch, both wait settings
    $display("[TB] directed: single fetch");
    doReset();
    sram_rdata = 32'hE3A01005;
    applyStimulus(1, 0, 0, 32'h40, 32'h0, 32'h0);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      checkOutput("fetch_re",     {31'h0, bus4.sram_re},  {31'h0, k >= 1 && k <= 4});
      checkOutput("fetch_ready",  {31'h0, bus4.if_ready}, {31'h0, k == 5});
      checkOutput("fetch_freeze", {31'h0, bus4.freeze},   {31'h0, k <= 4});
      if (k >= 1 && k <= 4) checkOutput("fetch_addr", bus4.sram_addr, 32'h40);
      if (k == 5) checkOutput("fetch_rdata", bus4.if_rdata, 32'hE3A01005);
      if (k <= 2) begin
        checkOutput("w1_re",    {31'h0, bus1.sram_re},  {31'h0, k == 1});
        checkOutput("w1_ready", {31'h0, bus1.if_ready}, {31'h0, k == 2});
      end
      nextCycle();
      if (k == 5) if_req = 1'b0;
    end

    // store
    $display("[TB] directed: store");
    doReset();
    applyStimulus(0, 0, 1, 32'h0, 32'h100, 32'hDEADBEEF);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      checkOutput("store_we",    {31'h0, bus4.sram_we},   {31'h0, k >= 1 && k <= 4});
      checkOutput("store_re",    {31'h0, bus4.sram_re},   32'h0);
      checkOutput("store_ready", {31'h0, bus4.mem_ready}, {31'h0, k == 5});
      if (k >= 1 && k <= 4) begin
        checkOutput("store_addr",  bus4.sram_addr,  32'h100);
        checkOutput("store_wdata", bus4.sram_wdata, 32'hDEADBEEF);
      end
      nextCycle();
      if (k == 5) mem_w_en = 1'b0;
    end

    // contention from reset: data side first, fetch second
    $display("[TB] directed: contention");
    doReset();
    sram_rdata = 32'h0BADF00D;
    applyStimulus(1, 1, 0, 32'h44, 32'h300, 32'h0);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      checkOutput("cont_mem_ready", {31'h0, bus4.mem_ready}, {31'h0, k == 5});
      checkOutput("cont_if_ready",  {31'h0, bus4.if_ready},  {31'h0, k == 11});
      if (k == 2) checkOutput("cont_addr_mem", bus4.sram_addr, 32'h300);
      if (k == 8) checkOutput("cont_addr_if",  bus4.sram_addr, 32'h44);
      nextCycle();
      if (k == 5)  mem_r_en = 1'b0;
      if (k == 11) if_req = 1'b0;
    end

    // load then simultaneous load+store: store wins, loaded word untouched
    $display("[TB] directed: load then read+write");
    doReset();
    sram_rdata = 32'h12345678;
    applyStimulus(0, 1, 0, 32'h0, 32'h200, 32'h0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) checkOutput("load_rdata", bus4.mem_rdata, 32'h12345678);
      nextCycle();
    end
    sram_rdata = 32'hAAAA5555;
    applyStimulus(0, 1, 1, 32'h0, 32'h204, 32'hCAFEF00D);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      checkOutput("rw_we",    {31'h0, bus4.sram_we},   {31'h0, k >= 1 && k <= 4});
      checkOutput("rw_re",    {31'h0, bus4.sram_re},   32'h0);
      checkOutput("rw_ready", {31'h0, bus4.mem_ready}, {31'h0, k == 5});
      checkOutput("rw_rdata", bus4.mem_rdata, 32'h12345678);
      nextCycle();
      if (k == 5) applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);
    end

    // reset in the middle of a fetch
    $display("[TB] directed: reset mid-access");
    doReset();
    sram_rdata = 32'h00000055;
    applyStimulus(1, 0, 0, 32'h80, 32'h0, 32'h0);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) checkOutput("abort_re_before", {31'h0, bus4.sram_re}, 32'h1);
      if (k >= 3) begin
        checkOutput("abort_re",     {31'h0, bus4.sram_re},  32'h0);
        checkOutput("abort_busy",   {31'h0, bus4.busy},     32'h0);
        checkOutput("abort_ready",  {31'h0, bus4.if_ready}, 32'h0);
        checkOutput("abort_rdata",  bus4.if_rdata, 32'h0);
      end
      nextCycle();
      if (k == 1) begin
        rst    = 1'b1;
        if_req = 1'b0;
      end
      if (k == 2) rst = 1'b0;
    end

    // random traffic, including dropped requests and occasional resets
    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) if_req   = ~if_req;
      if ($urandom_range(0, 3) == 0) mem_r_en = ~mem_r_en;
      if ($urandom_range(0, 5) == 0) mem_w_en = ~mem_w_en;
      if_addr    = $urandom;
      mem_addr   = $urandom;
      mem_wdata  = $urandom;
      sram_rdata = $urandom;
      nextCycle();
    end

    rst = 1'b0;
    nextCycle();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
